adc_trig_capture: RTL and testbench

- Consumes the packed 32-bit ADC word from the FMC AD9643 front-end: ch A in [13:0], ch B in [29:16], zeros elsewhere.
- Runs in the 250 MHz ADC data-clock domain.
- After an arm request, continuously records into a circular on-chip RAM (DEPTH = 2^ADDR_W words) and waits for a level-crossing trigger on a selected channel.
- Freezes a window holding i_pre_len pre-trigger samples, then streams the window out over a valid/ready interface to the DMA/analysis stage.

---
 rtl/adc_trig_capture.sv | 225 ++++++++++++++++++++++
 tb/tb_adc_trig_capture.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_trig_capture.sv
// adc_trig_capture: armed circular ADC capture with level trigger and stream read-out.
// Define ADC_CAP_DECIM_EN to add i_decim sample decimation.
module adc_trig_capture #(
  parameter int ADDR_W = 10
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_adc_data,
  input  logic              i_arm,
  input  logic              i_trig_ch,
  input  logic              i_trig_edge,
  input  logic [13:0]       i_trig_level,
  input  logic              i_force_trig,
  input  logic [ADDR_W-1:0] i_pre_len,
`ifdef ADC_CAP_DECIM_EN
  input  logic [7:0]        i_decim,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_m_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic              o_m_last
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_WAIT,
    S_POST,
    S_READ,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic ch_q, ch_d;
  logic edg_q, edg_d;
  logic signed [13:0] level_q, level_d;
  logic signed [13:0] prev_q, prev_d;
  logic signed [13:0] cur;
  logic pv_q, pv_d;

  logic [ADDR_W-1:0] pre_q, pre_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic [31:0] data_q, data_d;
  logic valid_q, valid_d;
  logic last_q, last_d;

  logic capt;
  logic acc;
  logic we;
  logic trig;
  logic ld;
  logic hs;

  logic [31:0] mem [DEPTH];

  assign capt = (state_q == S_PREFILL) ||
                (state_q == S_WAIT) ||
                (state_q == S_POST);

`ifdef ADC_CAP_DECIM_EN
  logic [7:0] dec_q, dec_d;
  logic [7:0] dcnt_q, dcnt_d;

  // dcnt counts down skipped cycles; zero marks an accepted sample
  assign acc = (dcnt_q == 8'd0);

  always_comb begin
    dec_d  = dec_q;
    dcnt_d = dcnt_q;
    if (state_q == S_IDLE && i_arm) begin
      dec_d  = i_decim;
      dcnt_d = 8'd0;
    end else if (capt) begin
      dcnt_d = acc ? dec_q : dcnt_q - 8'd1;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      dec_q  <= 8'd0;
      dcnt_q <= 8'd0;
    end else begin
      dec_q  <= dec_d;
      dcnt_q <= dcnt_d;
    end
  end
`else
  assign acc = 1'b1;
`endif

  assign we = capt && acc;

  assign cur = ch_q ? i_adc_data[29:16] : i_adc_data[13:0];

  assign trig = pv_q && (edg_q ?
    (prev_q > level_q && cur <= level_q) :
    (prev_q < level_q && cur >= level_q));

  assign hs = valid_q && i_m_ready;
  assign ld = (state_q == S_READ) && !cnt_q[ADDR_W] &&
              (!valid_q || i_m_ready);

  always_ff @(posedge i_sys_clk) begin
    if (we) mem[wptr_q] <= i_adc_data;
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    edg_d   = edg_q;
    level_d = level_q;
    pre_d   = pre_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    pv_d    = pv_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;

    if (we) begin
      wptr_d = wptr_q + 1'b1;
      prev_d = cur;
      pv_d   = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_arm) begin
          ch_d    = i_trig_ch;
          edg_d   = i_trig_edge;
          level_d = i_trig_level;
          // port width already bounds pre_len to DEPTH-1
          pre_d   = i_pre_len;
          wptr_d  = '0;
          pv_d    = 1'b0;
          state_d = (i_pre_len == '0) ? S_WAIT : S_PREFILL;
        end
      end
      S_PREFILL: begin
        if (we && wptr_q == pre_q - 1'b1) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (we && (trig || i_force_trig)) begin
          rptr_d  = wptr_q - pre_q;
          cnt_d   = '0;
          // full pre-window: the trigger sample is the last one
          state_d = (&pre_q) ? S_READ : S_POST;
        end
      end
      S_POST: begin
        if (we && wptr_q == rptr_q - 1'b1) state_d = S_READ;
      end
      S_READ: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) state_d = S_DONE;
        end
        if (ld) begin
          data_d  = mem[rptr_q];
          valid_d = 1'b1;
          last_d  = (cnt_q == LAST_CNT);
          rptr_d  = rptr_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= 1'b0;
      edg_q   <= 1'b0;
      level_q <= '0;
      pre_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      prev_q  <= '0;
      pv_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      edg_q   <= edg_d;
      level_q <= level_d;
      pre_q   <= pre_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      pv_q    <= pv_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = (state_q == S_DONE);
  assign o_m_data  = data_q;
  assign o_m_valid = valid_q;
  assign o_m_last  = last_q;

endmodule

// File: tb/tb_adc_trig_capture.sv
// tb_adc_trig_capture: directed bench for adc_trig_capture at ADDR_W=4.
// Scenarios cover triggers, stalls, forced trigger, resets and decimation.
module tb_adc_trig_capture;

  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_adc_data;
  logic        i_arm;
  logic        i_trig_ch;
  logic        i_trig_edge;
  logic [13:0] i_trig_level;
  logic        i_force_trig;
  logic [AW-1:0] i_pre_len;
`ifdef ADC_CAP_DECIM_EN
  logic [7:0]  i_decim;
`endif
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_m_data;
  logic        o_m_valid;
  logic        i_m_ready;
  logic        o_m_last;

  int total = 0;
  int bad = 0;

  int n;
  int ga0, gda, gbsw, gbhi, gblo;
  int force_at;

  logic [31:0] got[$];
  int last_at, last_cnt, done_at;
  int last_hs_c, first_v_c, stall_err;

  adc_trig_capture #(.ADDR_W(AW)) dut (
    .i_sys_clk    (clk),
    .i_rst_n      (i_rst_n),
    .i_adc_data   (i_adc_data),
    .i_arm        (i_arm),
    .i_trig_ch    (i_trig_ch),
    .i_trig_edge  (i_trig_edge),
    .i_trig_level (i_trig_level),
    .i_force_trig (i_force_trig),
    .i_pre_len    (i_pre_len),
`ifdef ADC_CAP_DECIM_EN
    .i_decim      (i_decim),
`endif
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_m_data     (o_m_data),
    .o_m_valid    (o_m_valid),
    .i_m_ready    (i_m_ready),
    .o_m_last     (o_m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int a, input int b);
    logic [13:0] aa;
    logic [13:0] bb;
    aa = a[13:0];
    bb = b[13:0];
    return {2'b00, bb, 2'b00, aa};
  endfunction

  task automatic drive_tick();
    i_adc_data   = pk(ga0 + gda * n, (n < gbsw) ? gbhi : gblo);
    i_force_trig = (n == force_at);
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic arm(input logic ch, input logic edg,
                     input int lvl, input int pre);
    i_trig_ch    = ch;
    i_trig_edge  = edg;
    i_trig_level = lvl[13:0];
    i_pre_len    = pre[AW-1:0];
    i_force_trig = 1'b0;
    i_arm        = 1'b1;
    @(posedge clk);
    #1;
    i_arm = 1'b0;
    n     = 0;
  endtask

  // mode 0: ready always high; mode 1: ready 1,0,0,1 over valid cycles
  task automatic run(input int mode, input int maxc, input int stop);
    logic [31:0] held;
    bit pend;
    bit rdy;
    int rc;
    got.delete();
    last_at   = -1;
    last_cnt  = 0;
    done_at   = -1;
    last_hs_c = -1;
    first_v_c = -1;
    stall_err = 0;
    pend      = 1'b0;
    held      = '0;
    rc        = 0;
    for (int c = 0; c < maxc; c++) begin
      if (pend && (!o_m_valid || o_m_data !== held)) stall_err++;
      if (o_done) begin
        done_at = c;
        break;
      end
      if (stop > 0 && got.size() >= stop) break;
      if (o_m_valid && first_v_c < 0) first_v_c = c;
      rdy = (mode == 0) || (rc % 4 == 0) || (rc % 4 == 3);
      if (o_m_valid) rc++;
      i_m_ready = rdy;
      if (o_m_valid && rdy) begin
        got.push_back(o_m_data);
        if (o_m_last) begin
          last_at = got.size() - 1;
          last_cnt++;
        end
        last_hs_c = c;
      end
      pend = o_m_valid && !rdy;
      held = o_m_data;
      drive_tick();
    end
    i_m_ready = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    drive_tick();
    drive_tick();
    total++;
    if (o_busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy got=%b exp=0", o_busy);
    end
    total++;
    if (o_done !== 1'b0) begin
      bad++; $display("FAIL rst_done got=%b exp=0", o_done);
    end
    total++;
    if (o_m_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b exp=0", o_m_valid);
    end
    total++;
    if (o_m_last !== 1'b0) begin
      bad++; $display("FAIL rst_last got=%b exp=0", o_m_last);
    end
    total++;
    if (o_m_data !== 32'h0) begin
      bad++; $display("FAIL rst_data got=%h exp=0", o_m_data);
    end
    i_rst_n = 1'b1;
    drive_tick();
  endtask

  task automatic test_rising();
    logic [31:0] e, w;
    ga0 = -100; gda = 10; gbsw = 0; gbhi = 0; gblo = 0;
    force_at = -1;
    arm(1'b0, 1'b0, 0, 4);
    total++;
    if (o_busy !== 1'b1) begin
      bad++; $display("FAIL t1_busy got=%b exp=1", o_busy);
    end
    run(0, 200, 0);
    total++;
    if (got.size() != 16) begin
      bad++; $display("FAIL t1_count got=%0d exp=16", got.size());
    end
    for (int i = 0; i < 16; i++) begin
      e = pk(-40 + 10 * i, 0);
      w = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
      total++;
      if (w !== e) begin
        bad++; $display("FAIL t1_word%0d got=%h exp=%h", i, w, e);
      end
    end
    total++;
    if (last_at != 15 || last_cnt != 1) begin
      bad++; $display("FAIL t1_last got=%0d/%0d exp=15/1", last_at, last_cnt);
    end
    total++;
    if (done_at < 0 || done_at != last_hs_c + 1) begin
      bad++; $display("FAIL t1_done got=%0d exp=%0d", done_at, last_hs_c + 1);
    end
    total++;
    if (last_hs_c - first_v_c != 15) begin
      bad++; $display("FAIL t1_bubble got=%0d exp=15", last_hs_c - first_v_c);
    end
    drive_tick();
    total++;
    if (o_busy !== 1'b0) begin
      bad++; $display("FAIL t1_idle got=%b exp=0", o_busy);
    end
  endtask

  task automatic test_falling();
    logic [31:0] e, w;
    ga0 = 0; gda = 1; gbsw = 6; gbhi = 200; gblo = 50;
    force_at = -1;
    arm(1'b1, 1'b1, 100, 4);
    run(0, 200, 0);
    total++;
    if (got.size() != 16) begin
      bad++; $display("FAIL t2_count got=%0d exp=16", got.size());
    end
    for (int i = 0; i < 16; i++) begin
      e = pk(2 + i, (2 + i < 6) ? 200 : 50);
      w = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
      total++;
      if (w !== e) begin
        bad++; $display("FAIL t2_word%0d got=%h exp=%h", i, w, e);
      end
    end
    total++;
    if (done_at < 0) begin
      bad++; $display("FAIL t2_done got=%0d exp=done", done_at);
    end
    drive_tick();
    arm(1'b0, 1'b1, 100, 4);
    for (int i = 0; i < 40; i++) drive_tick();
    total++;
    if (o_busy !== 1'b1) begin
      bad++; $display("FAIL t2_chA_busy got=%b exp=1", o_busy);
    end
    total++;
    if (o_m_valid !== 1'b0) begin
      bad++; $display("FAIL t2_chA_valid got=%b exp=0", o_m_valid);
    end
    i_rst_n = 1'b0;
    drive_tick();
    i_rst_n = 1'b1;
    total++;
    if (o_busy !== 1'b0) begin
      bad++; $display("FAIL t2_abort got=%b exp=0", o_busy);
    end
  endtask

  task automatic test_stall();
    logic [31:0] e, w;
    ga0 = -100; gda = 10; gbsw = 0; gbhi = 0; gblo = 0;
    force_at = -1;
    arm(1'b0, 1'b0, 0, 4);
    run(1, 300, 0);
    total++;
    if (got.size() != 16) begin
      bad++; $display("FAIL t3_count got=%0d exp=16", got.size());
    end
    for (int i = 0; i < 16; i++) begin
      e = pk(-40 + 10 * i, 0);
      w = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
      total++;
      if (w !== e) begin
        bad++; $display("FAIL t3_word%0d got=%h exp=%h", i, w, e);
      end
    end
    total++;
    if (stall_err != 0) begin
      bad++; $display("FAIL t3_hold got=%0d exp=0", stall_err);
    end
    total++;
    if (last_at != 15 || done_at < 0) begin
      bad++; $display("FAIL t3_last got=%0d/%0d exp=15/done", last_at, done_at);
    end
    drive_tick();
  endtask

  task automatic test_force_pre();
    logic [31:0] e, w;
    ga0 = 0; gda = 1; gbsw = 0; gbhi = 0; gblo = 0;
    force_at = 3;
    arm(1'b0, 1'b0, 8191, 0);
    run(0, 200, 0);
    force_at = -1;
    total++;
    if (got.size() != 16) begin
      bad++; $display("FAIL t4f_count got=%0d exp=16", got.size());
    end
    for (int i = 0; i < 16; i++) begin
      e = pk(3 + i, 0);
      w = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
      total++;
      if (w !== e) begin
        bad++; $display("FAIL t4f_word%0d got=%h exp=%h", i, w, e);
      end
    end
    drive_tick();
    ga0 = -200; gda = 10;
    arm(1'b0, 1'b0, 0, 15);
    run(0, 200, 0);
    total++;
    if (got.size() != 16) begin
      bad++; $display("FAIL t4m_count got=%0d exp=16", got.size());
    end
    for (int i = 0; i < 16; i++) begin
      e = pk(-150 + 10 * i, 0);
      w = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
      total++;
      if (w !== e) begin
        bad++; $display("FAIL t4m_word%0d got=%h exp=%h", i, w, e);
      end
    end
    total++;
    if (last_at != 15 || done_at < 0) begin
      bad++; $display("FAIL t4m_last got=%0d/%0d exp=15/done", last_at, done_at);
    end
    drive_tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] e, w;
    ga0 = -100; gda = 10; gbsw = 0; gbhi = 0; gblo = 0;
    force_at = -1;
    arm(1'b0, 1'b0, 0, 4);
    for (int i = 0; i < 14; i++) drive_tick();
    i_rst_n = 1'b0;
    drive_tick();
    i_rst_n = 1'b1;
    total++;
    if (o_busy !== 1'b0 || o_m_valid !== 1'b0) begin
      bad++; $display("FAIL t5_post got=%b%b exp=00", o_busy, o_m_valid);
    end
    arm(1'b0, 1'b0, 0, 4);
    run(0, 200, 3);
    i_rst_n = 1'b0;
    drive_tick();
    i_rst_n = 1'b1;
    total++;
    if (o_busy !== 1'b0 || o_m_valid !== 1'b0 || o_m_last !== 1'b0) begin
      bad++;
      $display("FAIL t5_read got=%b%b%b exp=000", o_busy, o_m_valid, o_m_last);
    end
    arm(1'b0, 1'b0, 0, 4);
    run(0, 200, 0);
    total++;
    if (got.size() != 16 || done_at < 0) begin
      bad++; $display("FAIL t5_fresh got=%0d exp=16", got.size());
    end
    for (int i = 0; i < 16; i++) begin
      e = pk(-40 + 10 * i, 0);
      w = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
      total++;
      if (w !== e) begin
        bad++; $display("FAIL t5f_word%0d got=%h exp=%h", i, w, e);
      end
    end
    drive_tick();
    ga0 = -300;
    arm(1'b0, 1'b0, 0, 4);
    for (int i = 0; i < 6; i++) drive_tick();
    i_trig_ch    = 1'b1;
    i_trig_edge  = 1'b1;
    i_trig_level = 14'h2c78;
    i_pre_len    = 4'd9;
    i_arm        = 1'b1;
    drive_tick();
    i_arm = 1'b0;
    total++;
    if (o_busy !== 1'b1) begin
      bad++; $display("FAIL t5_arm_busy got=%b exp=1", o_busy);
    end
    run(0, 300, 0);
    total++;
    if (got.size() != 16) begin
      bad++; $display("FAIL t5a_count got=%0d exp=16", got.size());
    end
    for (int i = 0; i < 16; i++) begin
      e = pk(-40 + 10 * i, 0);
      w = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
      total++;
      if (w !== e) begin
        bad++; $display("FAIL t5a_word%0d got=%h exp=%h", i, w, e);
      end
    end
    drive_tick();
  endtask

`ifdef ADC_CAP_DECIM_EN
  task automatic test_decim();
    logic [31:0] e, w;
    ga0 = 0; gda = 1; gbsw = 0; gbhi = 0; gblo = 0;
    force_at = -1;
    i_decim = 8'd2;
    arm(1'b0, 1'b0, 30, 4);
    run(0, 300, 0);
    i_decim = 8'd0;
    total++;
    if (got.size() != 16) begin
      bad++; $display("FAIL t6_count got=%0d exp=16", got.size());
    end
    for (int i = 0; i < 16; i++) begin
      e = pk(18 + 3 * i, 0);
      w = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
      total++;
      if (w !== e) begin
        bad++; $display("FAIL t6_word%0d got=%h exp=%h", i, w, e);
      end
    end
    drive_tick();
  endtask
`endif

  initial begin
    i_rst_n      = 1'b0;
    i_adc_data   = '0;
    i_arm        = 1'b0;
    i_trig_ch    = 1'b0;
    i_trig_edge  = 1'b0;
    i_trig_level = '0;
    i_force_trig = 1'b0;
    i_pre_len    = '0;
    i_m_ready    = 1'b1;
`ifdef ADC_CAP_DECIM_EN
    i_decim      = 8'd0;
`endif
    n = 0; ga0 = 0; gda = 0; gbsw = 0; gbhi = 0; gblo = 0;
    force_at = -1;
    test_reset();
    test_rising();
    test_falling();
    test_stall();
    test_force_pre();
    test_reset_mid();
`ifdef ADC_CAP_DECIM_EN
    test_decim();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
